px_sync_filt: RTL and testbench

Multi-channel asynchronous-input synchronizer with per-channel glitch filter and edge-pulse generation. Each of NUM_CH independent single-bit inputs passes through a SYNC_STAGE-deep flop chain into the clk domain, then through a stability filter that updates the output only after the synchronized value has differed from it for FILT_CNT consecutive cycles. It sits at the boundary of the core clock domain for slow asynchronous controls: external interrupts, straps, debug-request pins and level signals from other clock domains. It replaces hand-built sync-plus-edge-detect logic at each such point.

---
 rtl/px_sync_filt.sv | 88 ++++++++
 tb/tb_px_sync_filt.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/px_sync_filt.sv
// Per-channel asynchronous-input synchronizer followed by a stability filter
// that produces registered rise, fall and rejected-glitch pulses.
module px_sync_filt #(
  parameter int                NUM_CH     = 4,
  parameter int                SYNC_STAGE = 3,
  parameter int                FILT_CNT   = 1,
  parameter logic [NUM_CH-1:0] RST_VAL    = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] data_in,
  input  logic              hold,
  output logic [NUM_CH-1:0] data_out,
  output logic [NUM_CH-1:0] rise_pls,
  output logic [NUM_CH-1:0] fall_pls,
  output logic [NUM_CH-1:0] glitch_pls
);

  localparam int            CW       = (FILT_CNT > 1) ? $clog2(FILT_CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CNT - 1);

  logic [SYNC_STAGE-1:0][NUM_CH-1:0] sync_q, sync_d;
  logic [NUM_CH-1:0][CW-1:0]         cnt_q, cnt_d;
  logic [NUM_CH-1:0]                 data_q, data_d;
  logic [NUM_CH-1:0]                 rise_q, rise_d;
  logic [NUM_CH-1:0]                 fall_q, fall_d;
  logic [NUM_CH-1:0]                 glitch_q, glitch_d;
  logic [NUM_CH-1:0]                 sq;

  // The chain shifts every cycle; hold only freezes the filter stage.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = data_in;
    for (int j = 1; j < SYNC_STAGE; j++) begin
      sync_d[j] = sync_q[j-1];
    end
  end

  assign sq = sync_q[SYNC_STAGE-1];

  // cnt holds how many consecutive cycles sq has disagreed with data_out.
  always_comb begin
    data_d   = data_q;
    cnt_d    = cnt_q;
    rise_d   = '0;
    fall_d   = '0;
    glitch_d = '0;
    if (!hold) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sq[i] == data_q[i]) begin
          cnt_d[i]    = '0;
          glitch_d[i] = (cnt_q[i] != '0);
        end else if (cnt_q[i] == CNT_LAST) begin
          data_d[i] = sq[i];
          cnt_d[i]  = '0;
          rise_d[i] = sq[i];
          fall_d[i] = ~sq[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= {SYNC_STAGE{RST_VAL}};
      cnt_q    <= '0;
      data_q   <= RST_VAL;
      rise_q   <= '0;
      fall_q   <= '0;
      glitch_q <= '0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign data_out   = data_q;
  assign rise_pls   = rise_q;
  assign fall_pls   = fall_q;
  assign glitch_pls = glitch_q;

endmodule

// File: tb/tb_px_sync_filt.sv
// Directed and randomised bench for px_sync_filt: three parameterisations
// share stimulus; a history-based model is compared every cycle.
module tb_px_sync_filt;

  localparam logic [3:0] RV = 4'b1010;

  logic       clk;
  logic       rst_n;
  logic       hold;
  logic [3:0] data_in;

  logic [3:0] a_out, a_rise, a_fall, a_glt;
  logic [3:0] b_out, b_rise, b_fall, b_glt;
  logic [3:0] c_out, c_rise, c_fall, c_glt;

  int total = 0;
  int bad   = 0;

  // Instance order a, b, c: sync depth and filter length of each.
  int stg[3] = '{3, 2, 3};
  int flt[3] = '{1, 4, 3};

  logic [3:0] hist[$];
  logic [3:0] m_out[3];
  logic [3:0] m_rise[3];
  logic [3:0] m_fall[3];
  logic [3:0] m_glt[3];
  int         m_run[3][4];
  int         cd[4];

  px_sync_filt #(.NUM_CH(4), .SYNC_STAGE(3), .FILT_CNT(1), .RST_VAL(RV)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .hold(hold),
    .data_out(a_out), .rise_pls(a_rise), .fall_pls(a_fall), .glitch_pls(a_glt)
  );

  px_sync_filt #(.NUM_CH(4), .SYNC_STAGE(2), .FILT_CNT(4), .RST_VAL(RV)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .hold(hold),
    .data_out(b_out), .rise_pls(b_rise), .fall_pls(b_fall), .glitch_pls(b_glt)
  );

  px_sync_filt #(.NUM_CH(4), .SYNC_STAGE(3), .FILT_CNT(3), .RST_VAL(RV)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .hold(hold),
    .data_out(c_out), .rise_pls(c_rise), .fall_pls(c_fall), .glitch_pls(c_glt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard model: sq is simply the data_in sampled SYNC_STAGE edges ago
  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < 4; k++) hist.push_back(RV);
    for (int u = 0; u < 3; u++) begin
      m_out[u]  = RV;
      m_rise[u] = '0;
      m_fall[u] = '0;
      m_glt[u]  = '0;
      for (int c = 0; c < 4; c++) m_run[u][c] = 0;
    end
  endtask

  task automatic model_edge();
    for (int u = 0; u < 3; u++) begin
      logic [3:0] sv;
      sv        = hist[stg[u]-1];
      m_rise[u] = '0;
      m_fall[u] = '0;
      m_glt[u]  = '0;
      for (int c = 0; c < 4; c++) begin
        if (!hold) begin
          if (sv[c] == m_out[u][c]) begin
            if (m_run[u][c] != 0) m_glt[u][c] = 1'b1;
            m_run[u][c] = 0;
          end else begin
            m_run[u][c]++;
            if (m_run[u][c] == flt[u]) begin
              m_out[u][c] = sv[c];
              m_run[u][c] = 0;
              if (sv[c]) m_rise[u][c] = 1'b1;
              else       m_fall[u][c] = 1'b1;
            end
          end
        end
      end
    end
    hist.push_front(data_in);
    void'(hist.pop_back());
  endtask

  task automatic cmp_all();
    chk("a_out", a_out, m_out[0]);  chk("a_rise", a_rise, m_rise[0]);
    chk("a_fall", a_fall, m_fall[0]); chk("a_glt", a_glt, m_glt[0]);
    chk("b_out", b_out, m_out[1]);  chk("b_rise", b_rise, m_rise[1]);
    chk("b_fall", b_fall, m_fall[1]); chk("b_glt", b_glt, m_glt[1]);
    chk("c_out", c_out, m_out[2]);  chk("c_rise", c_rise, m_rise[2]);
    chk("c_fall", c_fall, m_fall[2]); chk("c_glt", c_glt, m_glt[2]);
  endtask

  // driver: one clock, model advance, then sample 1ns after the edge
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    cmp_all();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    cmp_all();
  endtask

  initial begin
    rst_n   = 1'b1;
    hold    = 1'b0;
    data_in = RV;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_a_out", a_out, 4'b1010);
    chk("rst_c_out", c_out, 4'b1010);
    chk("rst_a_pls", a_rise | a_fall | a_glt, 4'b0000);
    cmp_all();
    run(2);
    rst_n = 1'b1;
    run(3);
    chk("post_rst_a_out", a_out, 4'b1010);
    chk("post_rst_b_pls", b_rise | b_fall | b_glt, 4'b0000);

    // ch0 rises: a updates at k+3, b and c both at k+5
    data_in = 4'b1011;
    run(3);
    chk("lat_a_k2_rise", a_rise, 4'b0000);
    chk("lat_a_k2_out", a_out, 4'b1010);
    step();
    chk("lat_a_k3_rise", a_rise, 4'b0001);
    chk("lat_a_k3_out", a_out, 4'b1011);
    step();
    chk("lat_a_k4_rise", a_rise, 4'b0000);
    chk("lat_b_k4_rise", b_rise, 4'b0000);
    step();
    chk("lat_b_k5_rise", b_rise, 4'b0001);
    chk("lat_c_k5_rise", c_rise, 4'b0001);

    // 3-cycle high on ch1 is rejected by b (FILT_CNT=4)
    data_in = 4'b0001;
    run(12);
    data_in = 4'b0011;
    run(3);
    data_in = 4'b0001;
    run(3);
    chk("glt_b_pulse", b_glt, 4'b0010);
    chk("glt_b_out", b_out, 4'b0001);
    step();
    chk("glt_b_single", b_glt, 4'b0000);
    run(12);

    // ch1 held high: b updates at k+5
    data_in = 4'b0011;
    run(5);
    chk("filt_b_k4_rise", b_rise, 4'b0000);
    step();
    chk("filt_b_k5_rise", b_rise, 4'b0010);
    chk("filt_b_k5_out", b_out, 4'b0011);
    run(8);

    // ch2 rises; hold covers c's update edge k+5 for five edges
    data_in = 4'b0111;
    run(5);
    hold = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step();
      chk("hold_c_rise", c_rise, 4'b0000);
      chk("hold_c_out", c_out, 4'b0011);
    end
    hold = 1'b0;
    step();
    chk("hold_rel_c_rise", c_rise, 4'b0100);
    chk("hold_rel_c_out", c_out, 4'b0111);
    run(6);

    // ch3 rises; reset while c's counter is at 2
    data_in = 4'b1111;
    run(5);
    do_reset();
    chk("mid_rst_c_out", c_out, 4'b1010);
    chk("mid_rst_c_pls", c_rise | c_fall | c_glt, 4'b0000);
    chk("mid_rst_a_out", a_out, 4'b1010);
    run(2);
    rst_n = 1'b1;
    run(3);
    chk("re_lat_a_k2", a_rise, 4'b0000);
    step();
    chk("re_lat_a_k3", a_rise, 4'b0101);
    step();
    chk("re_lat_c_k4", c_rise, 4'b0000);
    step();
    chk("re_lat_c_k5", c_rise, 4'b0101);
    run(6);

    // all channels rise together
    data_in = 4'b0000;
    run(12);
    data_in = 4'b1111;
    run(3);
    chk("multi_a_k2", a_rise, 4'b0000);
    step();
    chk("multi_a_k3", a_rise, 4'b1111);
    chk("multi_a_out", a_out, 4'b1111);
    run(8);

    // random per-channel widths 1..10 with occasional hold
    for (int c = 0; c < 4; c++) cd[c] = $urandom_range(1, 10);
    for (int n = 0; n < 400; n++) begin
      logic [3:0] nd;
      nd = data_in;
      for (int c = 0; c < 4; c++) begin
        cd[c]--;
        if (cd[c] == 0) begin
          nd[c] = ~nd[c];
          cd[c] = $urandom_range(1, 10);
        end
      end
      data_in = nd;
      hold    = ($urandom_range(0, 7) == 0);
      step();
    end
    hold = 1'b0;
    run(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
